// File: rtl/cpu_multicycle_if.sv
// Instruction-memory fetch bus between the multi-cycle core (master) and its memory (slave).
interface cpu_multicycle_if;
    logic [31:0] PC;
    logic        INSTR_READ;
    logic [31:0] INSTRUCTION;
    logic        INSTR_BUSYWAIT;

    modport master (output PC, output INSTR_READ, input INSTRUCTION, input INSTR_BUSYWAIT);
    modport slave  (input PC, input INSTR_READ, output INSTRUCTION, output INSTR_BUSYWAIT);
endinterface

// File: rtl/cpu_multicycle.sv
// Parametrised multi-cycle core: FETCH/EXEC/WB sequencing, internal register file and ALU,
// sticky illegal-opcode flag and a combinational debug register read port.
module cpu_multicycle #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    cpu_multicycle_if.master      imem,
    output logic                  ILLEGAL,
    input  logic [REG_ADDR_W-1:0] DBG_ADDR,
    output logic [DATA_W-1:0]     DBG_DATA
);
    // state | meaning
    // IDLE  | out of reset, one edge before the first fetch
    // FETCH | INSTR_READ high; latch IR on an edge without busywait
    // EXEC  | read operands, register ALU result and branch decision
    // WB    | write RD (if any), load next PC, flag undefined opcodes

    localparam int NREG = 1 << REG_ADDR_W;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_BNE   = 8'h08;
    localparam logic [7:0] OP_SLL   = 8'h09;
    localparam logic [7:0] OP_SRL   = 8'h0A;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             ir_q, pc_q;
    logic [DATA_W-1:0]       regs [NREG];
    logic [DATA_W-1:0]       alu_q, alu_d;
    logic                    take_q, take_d;
    logic                    illegal_q;
    logic                    instr_read, ir_ld, exec_ld, wb_en;

    logic [7:0]              op, imm;
    logic [REG_ADDR_W-1:0]   rd_a, rs1_a, rs2_a;
    logic [DATA_W-1:0]       rs1, rs2;
    logic                    writes, undefined;
    logic [31:0]             br_target, pc_next;
    logic                    unused_ir;

    assign op        = ir_q[31:24];
    assign imm       = ir_q[7:0];
    assign rd_a      = ir_q[16 +: REG_ADDR_W];
    assign rs1_a     = ir_q[8 +: REG_ADDR_W];
    assign rs2_a     = ir_q[0 +: REG_ADDR_W];
    assign rs1       = regs[rs1_a];
    assign rs2       = regs[rs2_a];
    assign unused_ir = ^ir_q;

    assign br_target = pc_q + 32'd4 + {{22{ir_q[23]}}, ir_q[23:16], 2'b00};
    assign pc_next   = take_q ? br_target : pc_q + 32'd4;

    assign imem.PC         = pc_q;
    assign imem.INSTR_READ = instr_read;
    assign ILLEGAL         = illegal_q;
    assign DBG_DATA        = regs[DBG_ADDR];

    always_comb begin
        alu_d     = '0;
        take_d    = 1'b0;
        writes    = 1'b0;
        undefined = 1'b0;
        case (op)
            OP_LOADI: begin alu_d = DATA_W'(imm);             writes = 1'b1; end
            OP_MOV:   begin alu_d = rs2;                      writes = 1'b1; end
            OP_ADD:   begin alu_d = rs1 + rs2;                writes = 1'b1; end
            OP_SUB:   begin alu_d = rs1 + (~rs2) + DATA_W'(1); writes = 1'b1; end
            OP_AND:   begin alu_d = rs1 & rs2;                writes = 1'b1; end
            OP_OR:    begin alu_d = rs1 | rs2;                writes = 1'b1; end
            OP_J:     take_d = 1'b1;
            OP_BEQ:   take_d = (rs1 == rs2);
            OP_BNE:   take_d = (rs1 != rs2);
            // shift amounts of DATA_W or more flush the operand completely
            OP_SLL:   begin alu_d = (int'(imm) >= DATA_W) ? '0 : rs1 << imm; writes = 1'b1; end
            OP_SRL:   begin alu_d = (int'(imm) >= DATA_W) ? '0 : rs1 >> imm; writes = 1'b1; end
            default:  undefined = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        instr_read = 1'b0;
        ir_ld      = 1'b0;
        exec_ld    = 1'b0;
        wb_en      = 1'b0;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                instr_read = 1'b1;
                if (!imem.INSTR_BUSYWAIT) begin
                    ir_ld   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_ld = 1'b1;
                state_d = WB;
            end
            WB: begin
                wb_en   = 1'b1;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ir_q      <= '0;
            pc_q      <= '0;
            alu_q     <= '0;
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (ir_ld) ir_q <= imem.INSTRUCTION;
            if (exec_ld) begin
                alu_q  <= alu_d;
                take_q <= take_d;
            end
            if (wb_en) begin
                pc_q <= pc_next;
                if (undefined) illegal_q <= 1'b1;
            end
        end
    end

    // IR is frozen outside FETCH, so decode of it is still valid during WB
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && writes) begin
            regs[rd_a] <= alu_q;
        end
    end
endmodule

// File: tb/tb_cpu_multicycle.sv
// Self-checking bench: 8-bit and 16-bit cores run the same programs in lockstep; a monitor
// compares each retired instruction against a queue of hand-computed expectations.
module tb_cpu_multicycle;
    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    cpu_multicycle_if bus8 ();
    cpu_multicycle_if bus16 ();

    logic [31:0] instr = '0;
    logic        busy  = 1'b0;
    assign bus8.INSTRUCTION     = instr;
    assign bus8.INSTR_BUSYWAIT  = busy;
    assign bus16.INSTRUCTION    = instr;
    assign bus16.INSTR_BUSYWAIT = busy;

    logic        ill8, ill16;
    logic [2:0]  main_addr  = '0;
    logic [2:0]  mon_addr   = '0;
    logic        mon_active = 1'b0;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg8;
    logic [15:0] dbg16;
    assign dbg_addr = mon_active ? mon_addr : main_addr;

    cpu_multicycle #(.DATA_W(8), .REG_ADDR_W(3)) dut8 (
        .CLK(CLK), .RESET(RESET), .imem(bus8), .ILLEGAL(ill8),
        .DBG_ADDR(dbg_addr), .DBG_DATA(dbg8));
    cpu_multicycle #(.DATA_W(16), .REG_ADDR_W(3)) dut16 (
        .CLK(CLK), .RESET(RESET), .imem(bus16), .ILLEGAL(ill16),
        .DBG_ADDR(dbg_addr), .DBG_DATA(dbg16));

    typedef struct {
        logic [31:0] pc;
        int          en;
        logic [2:0]  dreg;
        logic [7:0]  v8;
        logic [15:0] v16;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] imem [16];
    int          stall_tab [16];
    logic [31:0] stall_addr = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          edges = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2};
    endfunction

    task automatic push(input logic [31:0] pc, input int en, input logic [2:0] dreg,
                        input logic [7:0] v8, input logic [15:0] v16, input logic ill);
        exp_t e;
        e.pc = pc; e.en = en; e.dreg = dreg; e.v8 = v8; e.v16 = v16; e.ill = ill;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) begin
            imem[i]      = '0;
            stall_tab[i] = 0;
        end
    endtask

    task automatic run(input string name, input int budget);
        int n;
        n = 0;
        @(negedge CLK); #2 RESET = 1'b0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        #3;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: %0d results outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // edges since reset release; edge 1 is IDLE -> FETCH
    initial forever begin
        @(posedge CLK);
        if (RESET) edges = 0;
        else       edges++;
    end

    // instruction memory with per-address stall counts; garbage whenever the word is not valid
    initial begin
        int          stall_cnt;
        logic        prev_rd, prev_busy;
        logic [3:0]  idx;
        stall_cnt = 0; prev_rd = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                stall_cnt = 0;
                prev_rd   = 1'b0;
                prev_busy = 1'b0;
            end else if (prev_rd && prev_busy) begin
                stall_cnt++;
                check("stall_read8", 32'(bus8.INSTR_READ), 32'd1);
                check("stall_pc8", bus8.PC, stall_addr);
                check("stall_pc16", bus16.PC, stall_addr);
            end else if (prev_rd) begin
                stall_cnt = 0;
            end
            idx   = bus8.PC[5:2];
            busy  = bus8.INSTR_READ && (stall_cnt < stall_tab[idx]);
            instr = (bus8.INSTR_READ && !busy) ? imem[idx] : 32'hDEAD_BEEF;
            prev_rd   = bus8.INSTR_READ;
            prev_busy = busy;
        end
    end

    // retirement = INSTR_READ rising again after a fetch was accepted
    initial begin
        logic prev_rd, accepted;
        exp_t e;
        prev_rd = 1'b0; accepted = 1'b0;
        forever begin
            @(negedge CLK);
            if (RESET) begin
                prev_rd  = 1'b0;
                accepted = 1'b0;
            end else begin
                if (prev_rd && !bus8.INSTR_READ) begin
                    accepted = 1'b1;
                end else if (!prev_rd && bus8.INSTR_READ && accepted) begin
                    accepted = 1'b0;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        mon_addr   = e.dreg;
                        mon_active = 1'b1;
                        #1;
                        check("ret_pc8", bus8.PC, e.pc);
                        check("ret_pc16", bus16.PC, e.pc);
                        check("ret_reg8", 32'(dbg8), 32'(e.v8));
                        check("ret_reg16", 32'(dbg16), 32'(e.v16));
                        check("ret_ill8", 32'(ill8), 32'(e.ill));
                        check("ret_ill16", 32'(ill16), 32'(e.ill));
                        check("ret_edge", edges, e.en);
                        mon_active = 1'b0;
                    end
                end
                prev_rd = bus8.INSTR_READ;
            end
        end
    end

    initial begin
        int n;
        // fill r1..r7 with nonzero values, then reset mid-cycle
        clear_mem();
        for (int i = 1; i < 8; i++) imem[i-1] = ins(8'h00, 8'(i), 8'h00, 8'(i * 17));
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b0;
        repeat (26) @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("rst_pc8", bus8.PC, 32'd0);
        check("rst_pc16", bus16.PC, 32'd0);
        check("rst_read8", 32'(bus8.INSTR_READ), 32'd0);
        check("rst_read16", 32'(bus16.INSTR_READ), 32'd0);
        check("rst_ill8", 32'(ill8), 32'd0);
        check("rst_ill16", 32'(ill16), 32'd0);
        for (int r = 0; r < 8; r++) begin
            main_addr = 3'(r);
            #1;
            check("rst_dbg8", 32'(dbg8), 32'd0);
            check("rst_dbg16", 32'(dbg16), 32'd0);
        end
        @(negedge CLK); #2 RESET = 1'b0;
        @(posedge CLK); #1;
        check("first_read8", 32'(bus8.INSTR_READ), 32'd1);
        check("first_read16", 32'(bus16.INSTR_READ), 32'd1);
        @(negedge CLK); #2 RESET = 1'b1;

        // arithmetic and logic
        clear_mem();
        imem[0] = ins(8'h00, 8'd1, 8'd0, 8'd5);
        imem[1] = ins(8'h00, 8'd2, 8'd0, 8'd3);
        imem[2] = ins(8'h03, 8'd3, 8'd1, 8'd2);
        imem[3] = ins(8'h03, 8'd4, 8'd2, 8'd1);
        imem[4] = ins(8'h02, 8'd5, 8'd4, 8'd4);
        imem[5] = ins(8'h04, 8'd6, 8'd1, 8'd4);
        imem[6] = ins(8'h05, 8'd7, 8'd2, 8'd4);
        imem[7] = ins(8'h01, 8'd1, 8'd0, 8'd3);
        push(32'd4,  4,  3'd1, 8'h05, 16'h0005, 1'b0);
        push(32'd8,  7,  3'd2, 8'h03, 16'h0003, 1'b0);
        push(32'd12, 10, 3'd3, 8'h02, 16'h0002, 1'b0);
        push(32'd16, 13, 3'd4, 8'hFE, 16'hFFFE, 1'b0);
        push(32'd20, 16, 3'd5, 8'hFC, 16'hFFFC, 1'b0);
        push(32'd24, 19, 3'd6, 8'h04, 16'h0004, 1'b0);
        push(32'd28, 22, 3'd7, 8'hFF, 16'hFFFF, 1'b0);
        push(32'd32, 25, 3'd1, 8'h02, 16'h0002, 1'b0);
        run("arith", 60);
        @(negedge CLK); #2 RESET = 1'b1;

        // three stalled fetch edges on the first instruction
        clear_mem();
        imem[0]      = ins(8'h00, 8'd1, 8'd0, 8'd7);
        stall_tab[0] = 3;
        stall_addr   = 32'd0;
        push(32'd4, 7, 3'd1, 8'h07, 16'h0007, 1'b0);
        run("wait", 30);
        @(negedge CLK); #2 RESET = 1'b1;

        // jump, taken BEQ with negative offset, untaken BNE
        clear_mem();
        imem[0] = ins(8'h06, 8'h01, 8'd0, 8'd0);
        imem[1] = ins(8'h08, 8'h05, 8'd1, 8'd1);
        imem[2] = ins(8'h07, 8'hFE, 8'd1, 8'd1);
        push(32'd8, 4,  3'd1, 8'h00, 16'h0000, 1'b0);
        push(32'd4, 7,  3'd1, 8'h00, 16'h0000, 1'b0);
        push(32'd8, 10, 3'd1, 8'h00, 16'h0000, 1'b0);
        run("branch", 30);
        @(negedge CLK); #2 RESET = 1'b1;

        // shifts, including amounts at and beyond the data width
        clear_mem();
        imem[0] = ins(8'h00, 8'd1, 8'd0, 8'hFF);
        imem[1] = ins(8'h09, 8'd2, 8'd1, 8'd4);
        imem[2] = ins(8'h0A, 8'd3, 8'd1, 8'd16);
        imem[3] = ins(8'h0A, 8'd4, 8'd2, 8'd4);
        imem[4] = ins(8'h09, 8'd5, 8'd1, 8'd8);
        push(32'd4,  4,  3'd1, 8'hFF, 16'h00FF, 1'b0);
        push(32'd8,  7,  3'd2, 8'hF0, 16'h0FF0, 1'b0);
        push(32'd12, 10, 3'd3, 8'h00, 16'h0000, 1'b0);
        push(32'd16, 13, 3'd4, 8'h0F, 16'h00FF, 1'b0);
        push(32'd20, 16, 3'd5, 8'h00, 16'hFF00, 1'b0);
        run("shift", 40);
        @(negedge CLK); #2 RESET = 1'b1;

        // undefined opcode at PC 12, then reset during EXEC of an ADD
        clear_mem();
        imem[0] = ins(8'h00, 8'd1, 8'd0, 8'h55);
        imem[1] = ins(8'h00, 8'd2, 8'd0, 8'h66);
        imem[2] = ins(8'h00, 8'd3, 8'd0, 8'h77);
        imem[3] = ins(8'hFF, 8'd1, 8'd1, 8'd1);
        imem[4] = ins(8'h00, 8'd4, 8'd0, 8'h01);
        imem[5] = ins(8'h02, 8'd1, 8'd1, 8'd1);
        push(32'd4,  4,  3'd1, 8'h55, 16'h0055, 1'b0);
        push(32'd8,  7,  3'd2, 8'h66, 16'h0066, 1'b0);
        push(32'd12, 10, 3'd3, 8'h77, 16'h0077, 1'b0);
        push(32'd16, 13, 3'd1, 8'h55, 16'h0055, 1'b1);
        push(32'd20, 16, 3'd4, 8'h01, 16'h0001, 1'b1);
        run("illegal", 40);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (bus8.INSTR_READ && n < 10);
        check("abort_in_exec", 32'(bus8.INSTR_READ), 32'd0);
        #2 RESET = 1'b1;
        main_addr = 3'd1;
        #1;
        check("abort_pc8", bus8.PC, 32'd0);
        check("abort_pc16", bus16.PC, 32'd0);
        check("abort_ill8", 32'(ill8), 32'd0);
        check("abort_ill16", 32'(ill16), 32'd0);
        check("abort_r1_8", 32'(dbg8), 32'd0);
        check("abort_r1_16", 32'(dbg16), 32'd0);
        repeat (2) @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
